// File: rtl/pipe_sub_32b.sv
// Two-stage pipelined carry-select subtractor/comparator.
// Stage 1 subtracts the low half and records its borrow; stage 2 computes the
// high half for both borrow cases, selects one, and registers the result and
// the comparison flags. Valid/ready handshakes sit on both sides.
module pipe_sub_32b #(
  parameter int WIDTH = 32,
  parameter int LOW_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             lt_s
);

  localparam int HI_W = WIDTH - LOW_W;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [LOW_W-1:0] lo_q, lo_d;
  logic             lo_borrow_q, lo_borrow_d;
  logic [HI_W-1:0]  a_hi_q, a_hi_d;
  logic [HI_W-1:0]  b_hi_q, b_hi_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             lt_s_q, lt_s_d;

  logic s2_adv, s1_adv, accept;
  logic [LOW_W:0] lo_sum;
  logic [HI_W:0]  hi_base, hi0, hi1, hi_sel;
  logic [WIDTH-1:0] diff_new;

  // Handshake: a stage may take new data when it is empty or its contents move on.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
    accept   = in_valid && s1_adv;
  end

  // Low-half subtraction as a + ~b + !bin; a missing carry means a borrow.
  always_comb begin
    lo_sum = {1'b0, a[LOW_W-1:0]} + {1'b0, ~b[LOW_W-1:0]} + {{LOW_W{1'b0}}, ~bin};
  end

  // Stage 1 next state: load only on accept, valid follows accept when advancing.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    lo_d        = lo_q;
    lo_borrow_d = lo_borrow_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    if (s1_adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      lo_d        = lo_sum[LOW_W-1:0];
      lo_borrow_d = !lo_sum[LOW_W];
      a_hi_d      = a[WIDTH-1:LOW_W];
      b_hi_d      = b[WIDTH-1:LOW_W];
      a_msb_d     = a[WIDTH-1];
      b_msb_d     = b[WIDTH-1];
    end
  end

  // High half for both borrow cases, selected by the low-half borrow.
  always_comb begin
    hi_base  = {1'b0, a_hi_q} + {1'b0, ~b_hi_q};
    hi0      = hi_base + {{HI_W{1'b0}}, 1'b1};
    hi1      = hi_base;
    hi_sel   = lo_borrow_q ? hi1 : hi0;
    diff_new = {hi_sel[HI_W-1:0], lo_q};
  end

  // Stage 2 next state: capture result and flags only when a valid stage-1 entry moves up.
  always_comb begin
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    lt_s_d     = lt_s_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q) begin
      diff_d = diff_new;
      bout_d = !hi_sel[HI_W];
      zero_d = (diff_new == '0);
      neg_d  = diff_new[WIDTH-1];
      ovf_d  = (a_msb_q != b_msb_q) && (diff_new[WIDTH-1] != a_msb_q);
      lt_s_d = diff_new[WIDTH-1] ^ ((a_msb_q != b_msb_q) && (diff_new[WIDTH-1] != a_msb_q));
    end
  end

  // Pipeline registers; reset clears valids and all data so nothing stale survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      lo_q        <= '0;
      lo_borrow_q <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      lt_s_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      lo_q        <= lo_d;
      lo_borrow_q <= lo_borrow_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      s2_valid_q  <= s2_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      lt_s_q      <= lt_s_d;
    end
  end

  // Outputs come straight from stage-2 registers.
  always_comb begin
    out_valid = s2_valid_q;
    diff      = diff_q;
    bout      = bout_q;
    zero      = zero_q;
    neg       = neg_q;
    ovf       = ovf_q;
    lt_s      = lt_s_q;
  end

endmodule
